// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin select generator for a 4-to-1 mux
// Grants one requester at a time, holds until req drop or HOLD_MAX acked beats.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             ack,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic             valid,
  output logic [CNT_W-1:0] beats
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] BEAT_SAT  = {CNT_W{1'b1}};

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       sel_nx;
  logic [3:0]       grant_nx;
  logic             valid_nx;
  logic [CNT_W-1:0] beats_nx;

  logic             found;
  logic [1:0]       pick;
  logic [1:0]       cand;
  logic             hold_hit;
  logic             release_now;

  // Search ptr+1, ptr+2, ptr+3, ptr; the last candidate wraps back to ptr.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign hold_hit    = (HOLD_MAX != 0) && ack && (beats == BEAT_LAST);
  assign release_now = !req[sel] || hold_hit;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    grant_nx = grant;
    valid_nx = valid;
    beats_nx = beats;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          sel_nx   = pick;
          grant_nx = 4'b0001 << pick;
          valid_nx = 1'b1;
          beats_nx = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // sel is left alone so the mux input does not move during the gap.
          state_nx = IDLE;
          ptr_nx   = sel;
          grant_nx = 4'b0000;
          valid_nx = 1'b0;
          beats_nx = '0;
        end else if (ack && (beats != BEAT_SAT)) begin
          beats_nx = beats + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
        valid_nx = 1'b0;
        beats_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'b11;
      sel   <= 2'b00;
      grant <= 4'b0000;
      valid <= 1'b0;
      beats <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      sel   <= sel_nx;
      grant <= grant_nx;
      valid <= valid_nx;
      beats <= beats_nx;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - scoreboard bench for mux_sel_arbiter
// Two builds (HOLD_MAX=4 and HOLD_MAX=0) share stimulus; each has its own reference model.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;

  logic [1:0] sel4, sel0;
  logic [3:0] grant4, grant0;
  logic       valid4, valid0;
  logic [2:0] beats4, beats0;

  mux_sel_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .sel(sel4), .grant(grant4), .valid(valid4), .beats(beats4)
  );

  mux_sel_arbiter #(.HOLD_MAX(0), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .sel(sel0), .grant(grant0), .valid(valid0), .beats(beats0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs packed as {sel, grant, valid, beats}.
  logic [9:0] q4[$];
  logic [9:0] q0[$];

  int m_owner[2];
  int m_beats[2];
  int m_last[2];
  int m_sel[2];
  int m_hold[2] = '{4, 0};

  task automatic model_step(input int d, input logic r, input logic [3:0] rq,
                            input logic a, output logic [9:0] e);
    logic [3:0] g;
    int         nb;
    if (r) begin
      m_owner[d] = -1;
      m_beats[d] = 0;
      m_last[d]  = 3;
      m_sel[d]   = 0;
    end else if (m_owner[d] < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last[d] + k) % 4;
        if (m_owner[d] < 0 && rq[c]) begin
          m_owner[d] = c;
          m_sel[d]   = c;
          m_beats[d] = 0;
        end
      end
    end else begin
      nb = a ? m_beats[d] + 1 : m_beats[d];
      if (!rq[m_owner[d]] || (a && m_hold[d] != 0 && nb == m_hold[d])) begin
        m_last[d]  = m_owner[d];
        m_owner[d] = -1;
        m_beats[d] = 0;
      end else begin
        m_beats[d] = (nb > 7) ? 7 : nb;
      end
    end
    g = (m_owner[d] >= 0) ? (4'b0001 << m_sel[d]) : 4'b0000;
    e = {2'(m_sel[d]), g, (m_owner[d] >= 0), 3'(m_beats[d])};
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic a);
    logic [9:0] e;
    @(negedge clk);
    rst = r;
    req = rq;
    ack = a;
    model_step(0, r, rq, a, e);
    q4.push_back(e);
    model_step(1, r, rq, a, e);
    q0.push_back(e);
  endtask

  task automatic compare(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got sel=%0d grant=%b valid=%b beats=%0d, expected sel=%0d grant=%b valid=%b beats=%0d",
               name, $time, act[9:8], act[7:4], act[3], act[2:0],
               exp[9:8], exp[7:4], exp[3], exp[2:0]);
    end
  endtask

  // Monitor: each edge realises exactly one queued prediction per build.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        compare("hold4", {sel4, grant4, valid4, beats4}, e);
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare("hold0", {sel0, grant0, valid0, beats0}, e);
      end
    end
  end

  initial begin
    logic [3:0] rq;
    // Reset held with all requests pending.
    drive(1'b1, 4'b1111, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    // Single request on 2, then drop.
    drive(1'b0, 4'b0100, 1'b0);
    drive(1'b0, 4'b0100, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    // All requesting with continuous ack: forced release every 4 beats.
    repeat (24) drive(1'b0, 4'b1111, 1'b1);
    // Grant on 1, late req[0] must not preempt; next goes to 2.
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b0, 4'b0010, 1'b0);
    drive(1'b0, 4'b0011, 1'b0);
    drive(1'b0, 4'b0011, 1'b1);
    drive(1'b0, 4'b0101, 1'b0);
    drive(1'b0, 4'b0101, 1'b0);
    drive(1'b0, 4'b0101, 1'b0);
    // Reset during a grant with beats=2.
    drive(1'b1, 4'b0000, 1'b0);
    repeat (3) drive(1'b0, 4'b1111, 1'b1);
    drive(1'b1, 4'b1111, 1'b1);
    drive(1'b0, 4'b1111, 1'b0);
    drive(1'b0, 4'b1111, 1'b0);
    // Long hold on source 0: saturation in the unlimited build.
    drive(1'b1, 4'b0000, 1'b0);
    repeat (20) drive(1'b0, 4'b0001, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b0);
    // Randomised traffic with occasional reset.
    rq = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 63) == 0), rq, 1'($urandom_range(0, 1)));
    end
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    for (int w = 0; w < 10 && (q4.size() > 0 || q0.size() > 0); w++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (q4.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d predictions left, expected 0/0", q4.size(), q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
